// File: rtl/etapa_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// default widths and the sign/zero extension helper used on both data paths.
package etapa_mem_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    // Keeps the low byte/halfword and extends it; any other size (incl. 2'b10) is a full word.
    function automatic logic [NB_DATA_DEF-1:0] mem_extend(
        input logic [NB_DATA_DEF-1:0] value,
        input logic [1:0]             size,
        input logic                   is_unsigned
    );
        logic [NB_DATA_DEF-1:0] result;
        case (size)
            MEM_BYTE: result = is_unsigned ? {{(NB_DATA_DEF-8){1'b0}}, value[7:0]}
                                           : {{(NB_DATA_DEF-8){value[7]}}, value[7:0]};
            MEM_HALF: result = is_unsigned ? {{(NB_DATA_DEF-16){1'b0}}, value[15:0]}
                                           : {{(NB_DATA_DEF-16){value[15]}}, value[15:0]};
            default:  result = value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/etapa_mem_data_memory.sv
// Word-organized data memory: synchronous write, combinational read, no reset.
// ETAPA_MEM_DEBUG_PORT_EN adds an independent raw read port for the debug unit.
module data_memory #(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 64,
    localparam int NB_ADDR  = $clog2(MEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_write_enable,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_write_data,
`ifdef ETAPA_MEM_DEBUG_PORT_EN
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB_DATA-1:0] o_debug_data,
`endif
    output logic [NB_DATA-1:0] o_read_data
);

    logic [NB_DATA-1:0] mem_array [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_write_enable) begin
            mem_array[i_addr] <= i_write_data;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle store is not forwarded.
    assign o_read_data = mem_array[i_addr];

`ifdef ETAPA_MEM_DEBUG_PORT_EN
    assign o_debug_data = mem_array[i_debug_addr];
`endif

endmodule

// File: rtl/etapa_mem.sv
// MEM stage: data memory access with byte/half/word formatting and the MEM/WB register.
// Optional debug read port enabled by ETAPA_MEM_DEBUG_PORT_EN.
module etapa_mem
    import etapa_mem_pkg::*;
#(
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int NB_REG    = NB_REG_DEF,
    parameter int MEM_DEPTH = 64,
    localparam int NB_ADDR  = $clog2(MEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
    input  logic [NB_DATA-1:0] i_ALU_result,
    input  logic               i_WB_write,
    input  logic               i_WB_mem_to_reg,
    input  logic               i_MEM_read,
    input  logic               i_MEM_write,
    input  logic               i_MEM_unsigned,
    input  logic [1:0]         i_MEM_byte_half_word,
`ifdef ETAPA_MEM_DEBUG_PORT_EN
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB_DATA-1:0] o_debug_data,
`endif
    output logic               o_WB_write,
    output logic               o_WB_mem_to_reg,
    output logic [NB_DATA-1:0] o_ALU_result,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_REG-1:0]  o_write_reg
);

    logic [NB_ADDR-1:0] word_index;
    logic [NB_DATA-1:0] store_word;
    logic [NB_DATA-1:0] mem_word;
    logic [NB_DATA-1:0] load_word;
    logic               write_enable;

    // Byte offset bits and anything above the memory size are ignored (address wraps).
    assign word_index   = i_ALU_result[NB_ADDR+1:2];
    assign store_word   = mem_extend(i_data_to_write_in_MEM, i_MEM_byte_half_word, i_MEM_unsigned);
    assign load_word    = mem_extend(mem_word, i_MEM_byte_half_word, i_MEM_unsigned);
    assign write_enable = i_MEM_write & i_reset;

    data_memory #(
        .NB_DATA   (NB_DATA),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_data_memory (
        .i_clk          (i_clk),
        .i_write_enable (write_enable),
        .i_addr         (word_index),
        .i_write_data   (store_word),
`ifdef ETAPA_MEM_DEBUG_PORT_EN
        .i_debug_addr   (i_debug_addr),
        .o_debug_data   (o_debug_data),
`endif
        .o_read_data    (mem_word)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_WB_write      <= 1'b0;
            o_WB_mem_to_reg <= 1'b0;
            o_ALU_result    <= '0;
            o_read_data     <= '0;
            o_write_reg     <= '0;
        end else begin
            o_WB_write      <= i_WB_write;
            o_WB_mem_to_reg <= i_WB_mem_to_reg;
            o_ALU_result    <= i_ALU_result;
            o_read_data     <= i_MEM_read ? load_word : '0;
            o_write_reg     <= i_write_reg;
        end
    end

endmodule

// File: tb/tb_etapa_mem.sv
// Directed table-driven bench for etapa_mem: store/load formatting, pass-through,
// read-during-write, address wrap and asynchronous reset behaviour.
module tb_etapa_mem;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [4:0]  i_write_reg;
    logic [31:0] i_data_to_write_in_MEM;
    logic [31:0] i_ALU_result;
    logic        i_WB_write;
    logic        i_WB_mem_to_reg;
    logic        i_MEM_read;
    logic        i_MEM_write;
    logic        i_MEM_unsigned;
    logic [1:0]  i_MEM_byte_half_word;
    logic        o_WB_write;
    logic        o_WB_mem_to_reg;
    logic [31:0] o_ALU_result;
    logic [31:0] o_read_data;
    logic [4:0]  o_write_reg;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    etapa_mem dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_write_reg            (i_write_reg),
        .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
        .i_ALU_result           (i_ALU_result),
        .i_WB_write             (i_WB_write),
        .i_WB_mem_to_reg        (i_WB_mem_to_reg),
        .i_MEM_read             (i_MEM_read),
        .i_MEM_write            (i_MEM_write),
        .i_MEM_unsigned         (i_MEM_unsigned),
        .i_MEM_byte_half_word   (i_MEM_byte_half_word),
        .o_WB_write             (o_WB_write),
        .o_WB_mem_to_reg        (o_WB_mem_to_reg),
        .o_ALU_result           (o_ALU_result),
        .o_read_data            (o_read_data),
        .o_write_reg            (o_write_reg)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [200];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input logic uns);
        i_MEM_write            = wr;
        i_MEM_read             = rd;
        i_ALU_result           = addr;
        i_data_to_write_in_MEM = data;
        i_MEM_byte_half_word   = size;
        i_MEM_unsigned         = uns;
        i_WB_write             = rd;
        i_WB_mem_to_reg        = rd;
        i_write_reg            = addr[6:2];
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int n = 0;
        // Five store/load phases of 20 words each, expected values from the test plan.
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < 20; j++) begin
                logic [31:0] sdata;
                logic [1:0]  ssize;
                logic        suns;
                case (t)
                    0:       begin sdata = j;                ssize = 2'b11; suns = 1'b1; end
                    1:       begin sdata = 32'hFFFFFFFF - j; ssize = 2'b01; suns = 1'b1; end
                    2:       begin sdata = 32'hFFFFFFFF - j; ssize = 2'b00; suns = 1'b1; end
                    3:       begin sdata = 32'h000000FF - j; ssize = 2'b11; suns = 1'b1; end
                    default: begin sdata = 32'h000000FF - j; ssize = 2'b00; suns = 1'b0; end
                endcase
                vecs[n] = '{1'b1, 1'b0, 32'(4*j), sdata, ssize, suns, 32'h0};
                n++;
            end
            for (int j = 0; j < 20; j++) begin
                case (t)
                    0:       vecs[n] = '{1'b0, 1'b1, 32'(4*j), 32'h0, 2'b11, 1'b1, 32'(j)};
                    1:       vecs[n] = '{1'b0, 1'b1, 32'(4*j), 32'h0, 2'b01, 1'b1, 32'h0000FFFF - j};
                    2:       vecs[n] = '{1'b0, 1'b1, 32'(4*j), 32'h0, 2'b00, 1'b1, 32'h000000FF - j};
                    3:       vecs[n] = '{1'b0, 1'b1, 32'(4*j), 32'h0, 2'b00, 1'b0, 32'hFFFFFFFF - j};
                    default: vecs[n] = '{1'b0, 1'b1, 32'(4*j), 32'h0, 2'b11, 1'b0, 32'hFFFFFFFF - j};
                endcase
                n++;
            end
        end

        // Reset state
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        check("reset_read_data", o_read_data, 32'h0);
        check("reset_alu", o_ALU_result, 32'h0);
        check("reset_ctrl", {29'h0, o_WB_write, o_WB_mem_to_reg, 1'b0}, 32'h0);
        #3 i_reset = 1'b1;
        step();

        for (int i = 0; i < 200; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].uns);
            step();
            $display("vec %0d wr=%0b rd=%0b addr=0x%02h size=%0d read_data=0x%08h exp=0x%08h",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].size, o_read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_read_data", i), o_read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_alu", i), o_ALU_result, vecs[i].addr);
            check($sformatf("vec%0d_wb_write", i), {31'h0, o_WB_write}, {31'h0, vecs[i].rd});
        end

        // Read and write the same word in one cycle: old data first, new data next cycle.
        drive(1'b1, 1'b0, 32'h40, 32'hAAAA5555, 2'b11, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h40, 32'h12345678, 2'b11, 1'b0);
        step();
        $display("rdw same-cycle read_data=0x%08h", o_read_data);
        check("rdw_old", o_read_data, 32'hAAAA5555);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 2'b11, 1'b0);
        step();
        $display("rdw next read_data=0x%08h", o_read_data);
        check("rdw_new", o_read_data, 32'h12345678);

        // Address wrap and ignored low bits; size 2'b10 acts as word.
        drive(1'b0, 1'b1, 32'h143, 32'h0, 2'b10, 1'b0);
        step();
        $display("wrap addr=0x143 read_data=0x%08h", o_read_data);
        check("wrap_size10", o_read_data, 32'h12345678);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 2'b01, 1'b0);
        step();
        $display("half signed addr=0x40 read_data=0x%08h", o_read_data);
        check("half_signed", o_read_data, 32'h00005678);

        // Mid-cycle async reset with nonzero outputs; a store during reset is dropped.
        drive(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'b11, 1'b0);
        #2 i_reset = 1'b0;
        #1;
        $display("async reset read_data=0x%08h alu=0x%08h", o_read_data, o_ALU_result);
        check("areset_read_data", o_read_data, 32'h0);
        check("areset_alu", o_ALU_result, 32'h0);
        check("areset_write_reg", {27'h0, o_write_reg}, 32'h0);
        check("areset_ctrl", {30'h0, o_WB_write, o_WB_mem_to_reg}, 32'h0);
        @(posedge i_clk);
        #3 i_reset = 1'b1;
        drive(1'b0, 1'b1, 32'h40, 32'h0, 2'b11, 1'b0);
        step();
        $display("after reset read_data=0x%08h", o_read_data);
        check("reset_store_suppressed", o_read_data, 32'h12345678);

        // Pass-through with no load.
        drive(1'b0, 1'b0, 32'h1234, 32'hFFFFFFFF, 2'b11, 1'b0);
        i_write_reg     = 5'd7;
        i_WB_write      = 1'b1;
        i_WB_mem_to_reg = 1'b1;
        step();
        $display("passthru write_reg=%0d alu=0x%08h read_data=0x%08h", o_write_reg, o_ALU_result, o_read_data);
        check("pt_write_reg", {27'h0, o_write_reg}, 32'd7);
        check("pt_wb_write", {31'h0, o_WB_write}, 32'd1);
        check("pt_mem_to_reg", {31'h0, o_WB_mem_to_reg}, 32'd1);
        check("pt_alu", o_ALU_result, 32'h1234);
        check("pt_read_data_zero", o_read_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/etapa_mem.md
Name: etapa_mem

Overview:
MEM stage of the 5-stage MIPS pipeline, between EX/MEM and WB.
- Holds a word-organized data memory.
- Performs loads and stores of byte, halfword or word size, with signed or unsigned extension.
- Registers results plus WB control into the MEM/WB pipeline register for the write-back stage.

Parameters:
- NB_DATA, 32: data/ALU width.
- NB_REG, 5: register-index width.
- MEM_DEPTH, 64: data memory depth in 32-bit words; must be a power of 2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_write_reg  in  NB_REG  destination register for WB.
- i_data_to_write_in_MEM  in  NB_DATA  store data (rt value).
- i_ALU_result  in  NB_DATA  byte address for loads/stores; also passed through.
- i_WB_write  in  1  instruction writes the register file.
- i_WB_mem_to_reg  in  1  WB mux select, passed through.
- i_MEM_read  in  1  load.
- i_MEM_write  in  1  store.
- i_MEM_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- i_MEM_byte_half_word  in  2  00 byte, 01 halfword, 11 word; 10 treated as word.
- o_WB_write  out  1  registered i_WB_write.
- o_WB_mem_to_reg  out  1  registered i_WB_mem_to_reg.
- o_ALU_result  out  NB_DATA  registered i_ALU_result.
- o_read_data  out  NB_DATA  registered formatted load data.
- o_write_reg  out  NB_REG  registered i_write_reg.

Behaviour:
- Reset low (async) clears all five outputs to 0. Memory contents are not reset.
- Word index = i_ALU_result[log2(MEM_DEPTH)+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo 4*MEM_DEPTH.
- Size always selects the LOW bits of the word; there is no byte-lane selection by address.
- Store path, on a rising edge with i_MEM_write=1:
  - The whole 32-bit word is written.
  - Byte: value = ext(data[7:0]). Halfword: value = ext(data[15:0]). Word: data unchanged.
  - ext = zero-extend if i_MEM_unsigned=1, else sign-extend.
- Load path:
  - Memory read is asynchronous (combinational) from the word index.
  - The word is formatted: byte = ext(word[7:0]), half = ext(word[15:0]), word = unchanged.
  - The formatted value is captured into o_read_data on the rising edge when i_MEM_read=1; o_read_data captures 0 when i_MEM_read=0.
- Latency: every output reflects the inputs present before the preceding rising edge (1 cycle).
- Read and write in the same cycle to the same word: o_read_data gets the OLD contents; the new value is visible from the next cycle.
- Reset asserted during a store: the write is suppressed while reset is low.

Optional Feature:
- Macro: ETAPA_MEM_DEBUG_PORT_EN.
- Defined: adds input i_debug_addr [log2(MEM_DEPTH)-1:0] (word index) and output o_debug_data [NB_DATA-1:0].
  - o_debug_data is a combinational read of the raw stored word, independent of the pipeline, for the debug unit.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - size encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11;
  - NB_DATA and NB_REG defaults;
  - an extension helper function (value, size, unsigned) reused for store and load formatting.
- One natural sub-module, data_memory:
  - MEM_DEPTH x NB_DATA array, synchronous write enable, asynchronous read, no reset;
  - carries the debug read port under the macro.
- Formatting logic and the MEM/WB register stay in etapa_mem.

Test Plan:
1. Word store then load: write data j to address 4j, j=0..19, size 11. Reading back size 11 gives o_read_data=j one cycle after each address is applied.
2. Half unsigned: store 0xFFFFFFFF-j at 4j with size 01, unsigned. Load size 01 unsigned gives 0x0000FFFF-j (j=0 gives 0x0000FFFF).
3. Byte unsigned: same stimulus with size 00. Load gives 0x000000FF-j (j=19 gives 0x000000EC).
4. Word store 0x000000FF-j unsigned, then byte load signed: gives 0xFFFFFFFF-j (sign-extended, e.g. j=19 gives 0xFFFFFFEC).
5. Byte store 0x000000FF-j signed, then word load: gives 0xFFFFFFFF-j (extension applied at store).
6. Reset and pipeline pass-through:
   - With outputs nonzero, pull i_reset low mid-cycle: all outputs read 0 immediately.
   - After release, i_write_reg=5'd7, i_WB_write=1, i_WB_mem_to_reg=1, i_ALU_result=0x1234 appear on the outputs after one edge.
   - o_read_data=0 when i_MEM_read=0.
